aes_key_schedule_ctrl: RTL

//  Sequences the combinational key_expansion datapath to produce all 11 AES-128 round keys,
//  one round per clock, and holds them in a register file. Adds the Rcon correction

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_key_schedule_ctrl_if.sv | 23 ++
 rtl/aes_key_schedule_ctrl_key_expansion.sv | 48 ++++
 rtl/aes_key_schedule_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, sizes and GF(2^8) helpers.
package aes_pkg;

   localparam int NUM_ROUNDS  = 10;
   localparam int AES_BLOCK_W = 128;

   typedef logic [AES_BLOCK_W-1:0] round_key_t;

   typedef enum logic [1:0] {
      KS_IDLE,
      KS_EXPAND,
      KS_DONE
   } ks_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column chaining carries the column-0 Rcon into every later column.
   function automatic round_key_t rcon_mask(input logic [7:0] r);
      return {24'h0, r, 24'h0, r, 24'h0, r, 24'h0, r};
   endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-load / round-key read bundle between loader, schedule and cipher.
interface aes_key_schedule_ctrl_if;
   import aes_pkg::*;

   logic       start;
   round_key_t key_in;
   logic       busy;
   logic       done;
   logic       keys_valid;
   logic [3:0] rk_rd_idx;
   round_key_t rk_rd_data;

   modport master (
      output start, key_in, rk_rd_idx,
      input  busy, done, keys_valid, rk_rd_data
   );

   modport slave (
      input  start, key_in, rk_rd_idx,
      output busy, done, keys_valid, rk_rd_data
   );

endinterface

// File: rtl/aes_key_schedule_ctrl_key_expansion.sv
// One AES-128 key-expansion step without Rcon: RotWord, SubWord, column chain.
module key_expansion
   import aes_pkg::*;
(
   input  round_key_t key_in,
   output round_key_t key_out
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub;
   logic [31:0] n0, n1, n2, n3;

   always_comb begin
      w0 = key_in[31:0];
      w1 = key_in[63:32];
      w2 = key_in[95:64];
      w3 = key_in[127:96];
      // Byte 0 sits in the low bits, so RotWord is a right rotate here.
      rot = {w3[7:0], w3[31:8]};
      sub = {SBOX[rot[31:24]], SBOX[rot[23:16]],
             SBOX[rot[15:8]],  SBOX[rot[7:0]]};
      n0 = w0 ^ sub;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      key_out = {n3, n2, n1, n0};
   end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 round-key sequencer: one expansion per clock into an 11-entry
// register file, with Rcon applied outside the expansion datapath.
module aes_key_schedule_ctrl
   import aes_pkg::*;
#(
   parameter int DATA_WIDTH = AES_BLOCK_W,
   parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
   input logic                    clk,
   input logic                    rst_n,
   aes_key_schedule_ctrl_if.slave ks
);

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   ks_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] rcon_q, rcon_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       kv_q, kv_d;

   round_key_t rk_q [0:NUM_ROUNDS];
   round_key_t rk_d [0:NUM_ROUNDS];

   logic [3:0]            prev_idx;
   round_key_t            ke_in;
   round_key_t            ke_out;
   logic [DATA_WIDTH-1:0] rd_data;

   always_comb begin
      prev_idx = cnt_q - 4'd1;
      ke_in    = (prev_idx <= LAST) ? rk_q[prev_idx] : '0;
   end

   key_expansion u_kexp (
      .key_in  (ke_in),
      .key_out (ke_out)
   );

   always_comb begin
      rd_data = '0;
      if (ks.rk_rd_idx <= LAST)
         rd_data = rk_q[ks.rk_rd_idx];
   end

   assign ks.rk_rd_data = rd_data;
   assign ks.busy       = busy_q;
   assign ks.done       = done_q;
   assign ks.keys_valid = kv_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcon_d  = rcon_q;
      kv_d    = kv_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rk_d    = rk_q;
      unique case (state_q)
         KS_IDLE: begin
            if (ks.start) begin
               rk_d[0] = ks.key_in;
               cnt_d   = 4'd1;
               rcon_d  = 8'h01;
               kv_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = KS_EXPAND;
            end
         end
         KS_EXPAND: begin
            rk_d[cnt_q] = ke_out ^ rcon_mask(rcon_q);
            rcon_d      = xtime(rcon_q);
            cnt_d       = cnt_q + 4'd1;
            busy_d      = 1'b1;
            if (cnt_q == LAST) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               kv_d    = 1'b1;
               state_d = KS_DONE;
            end
         end
         KS_DONE: begin
            cnt_d   = 4'd0;
            state_d = KS_IDLE;
         end
         default: begin
            state_d = KS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= KS_IDLE;
         cnt_q   <= 4'd0;
         rcon_q  <= 8'h01;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         kv_q    <= 1'b0;
         for (int i = 0; i <= NUM_ROUNDS; i++)
            rk_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rcon_q  <= rcon_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         kv_q    <= kv_d;
         rk_q    <= rk_d;
      end
   end

endmodule
